// File: rtl/pc_sequencer_if.sv
// Bus bundle between the PC sequencer and its environment: launch handshake,
// decode/flag inputs and the instruction-address/status outputs.
interface pc_sequencer_if #(
  parameter int D  = 12,
  parameter int CW = 16
);
  logic          start;
  logic          stall;
  logic          branch_en;
  logic          cond;
  logic [D-1:0]  target;
  logic          halt;
  logic [D-1:0]  prog_counter;
  logic          running;
  logic          done;
  logic          fault;
  logic [CW-1:0] inst_count;

  // Driver side: launches the program and supplies decode flags.
  modport master (
    output start, stall, branch_en, cond, target, halt,
    input  prog_counter, running, done, fault, inst_count
  );

  // Sequencer side.
  modport slave (
    input  start, stall, branch_en, cond, target, halt,
    output prog_counter, running, done, fault, inst_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the instruction address, advances or
// branches each RUN cycle, and runs the Start/Done launch handshake.
// A taken branch to target 0 is treated as a missing LUT entry (fault).
module pc_sequencer #(
  parameter int D  = 12,
  parameter int CW = 16
) (
  input logic         clk,
  input logic         rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [D-1:0]  pc, pc_next;
  logic [CW-1:0] count, count_next;
  logic          fault, fault_next;
  logic [CW-1:0] count_inc;
  logic          taken;

  assign taken     = bus.branch_en & bus.cond;
  assign count_inc = (count == {CW{1'b1}}) ? count : count + CW'(1);

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      count <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      count <= count_next;
      fault <= fault_next;
    end
  end

  // Next-state and datapath selection; RUN actions follow halt > stall > fault > branch > step.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    count_next = count;
    fault_next = fault;
    case (state)
      IDLE: begin
        if (bus.start) state_next = ARMED;
      end
      ARMED: begin
        pc_next    = '0;
        count_next = '0;
        fault_next = 1'b0;
        if (!bus.start) state_next = RUN;
      end
      RUN: begin
        if (bus.halt) begin
          state_next = DONE;
          count_next = count_inc;
        end else if (bus.stall) begin
          state_next = RUN;
        end else if (taken && (bus.target == '0)) begin
          fault_next = 1'b1;
          state_next = DONE;
          count_next = count_inc;
        end else if (taken) begin
          pc_next    = bus.target;
          count_next = count_inc;
        end else begin
          pc_next    = pc + D'(1);
          count_next = count_inc;
        end
      end
      DONE: begin
        if (bus.start) state_next = ARMED;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.prog_counter = pc;
  assign bus.inst_count   = count;
  assign bus.fault        = fault;
  assign bus.running      = (state == RUN);
  assign bus.done         = (state == DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: launch, branching, stall and
// halt priority, fault recovery, wrap, asynchronous reset and count saturation.
module tb_pc_sequencer;

  logic clk;
  logic rst;
  int   check_count;
  int   pass_count;

  pc_sequencer_if #(.D(12), .CW(16)) m ();
  pc_sequencer_if #(.D(12), .CW(4))  s ();

  pc_sequencer #(.D(12), .CW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m)
  );

  pc_sequencer #(.D(12), .CW(4)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (s)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the main sequencer's decode inputs.
  task automatic apply_stimulus(input logic start, input logic stall,
                                input logic branch_en, input logic cond,
                                input logic [11:0] target, input logic halt);
    m.start     = start;
    m.stall     = stall;
    m.branch_en = branch_en;
    m.cond      = cond;
    m.target    = target;
    m.halt      = halt;
  endtask

  // One comparison: counts it and reports any difference.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic check_main(input string tag, input int pc, input int cnt,
                            input logic run, input logic dn, input logic flt);
    check_output({tag, ".pc"},      32'(m.prog_counter), 32'(pc));
    check_output({tag, ".count"},   32'(m.inst_count),   32'(cnt));
    check_output({tag, ".running"}, 32'(m.running),      32'(run));
    check_output({tag, ".done"},     32'(m.done),         32'(dn));
    check_output({tag, ".fault"},   32'(m.fault),        32'(flt));
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0, 12'd0, 0);
    s.start = 0; s.stall = 0; s.branch_en = 0; s.cond = 0; s.target = '0; s.halt = 0;

    #12;
    check_main("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Idle ignores run-time inputs.
    apply_stimulus(0, 0, 1, 1, 12'd55, 0);
    tick();
    check_main("idle_hold", 0, 0, 0, 0, 0);

    // Launch: Start high two edges, then low.
    apply_stimulus(1, 0, 0, 0, 12'd0, 0);
    tick();
    tick();
    check_main("armed", 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 12'd0, 0);
    tick();
    check_main("run_first", 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_output("straight.pc", 32'(m.prog_counter), 32'(i));
    end
    tick();
    check_main("straight5", 5, 5, 1, 0, 0);

    // Walk to PC=10, then a taken branch and a not-taken branch.
    repeat (5) tick();
    check_main("at10", 10, 10, 1, 0, 0);
    apply_stimulus(0, 0, 1, 1, 12'd61, 0);
    tick();
    check_main("branch_taken", 61, 11, 1, 0, 0);
    apply_stimulus(0, 0, 1, 0, 12'd61, 0);
    tick();
    check_main("branch_not_taken", 62, 12, 1, 0, 0);
    apply_stimulus(0, 0, 0, 1, 12'd300, 0);
    tick();
    check_main("cond_no_en", 63, 13, 1, 0, 0);

    // Stall at PC=20 for three cycles; Start high during RUN is ignored.
    apply_stimulus(0, 0, 1, 1, 12'd20, 0);
    tick();
    check_main("to20", 20, 14, 1, 0, 0);
    apply_stimulus(1, 1, 1, 1, 12'd99, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_main("stall", 20, 14, 1, 0, 0);
    end

    // Halt with Stall and a taken zero-target branch: halt wins, no fault.
    apply_stimulus(0, 1, 1, 1, 12'd0, 1);
    tick();
    check_main("halt", 20, 15, 0, 1, 0);
    apply_stimulus(0, 0, 1, 1, 12'd5, 1);
    tick();
    check_main("done_hold", 20, 15, 0, 1, 0);

    // Relaunch from DONE.
    apply_stimulus(1, 0, 0, 0, 12'd0, 0);
    tick();
    check_main("rearm", 20, 15, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 12'd0, 0);
    tick();
    check_main("relaunch", 0, 0, 1, 0, 0);

    // Fault: branch to 7, then taken branch with target 0.
    apply_stimulus(0, 0, 1, 1, 12'd7, 0);
    tick();
    check_main("to7", 7, 1, 1, 0, 0);
    apply_stimulus(0, 0, 1, 1, 12'd0, 0);
    tick();
    check_main("fault", 7, 2, 0, 1, 1);
    apply_stimulus(1, 0, 0, 0, 12'd0, 0);
    tick();
    check_main("fault_rearm", 7, 2, 0, 0, 1);
    tick();
    check_main("fault_clear", 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 12'd0, 0);
    tick();
    check_main("run_again", 0, 0, 1, 0, 0);

    // Wrap 4095 -> 0 without fault.
    apply_stimulus(0, 0, 1, 1, 12'd4095, 0);
    tick();
    check_main("to4095", 4095, 1, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 12'd0, 0);
    tick();
    check_main("wrap", 0, 2, 1, 0, 0);

    // Asynchronous reset between edges at PC=73.
    apply_stimulus(0, 0, 1, 1, 12'd73, 0);
    tick();
    check_main("to73", 73, 3, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 12'd0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_main("async_reset", 0, 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    tick();
    tick();
    check_main("post_reset_idle", 0, 0, 0, 0, 0);

    // Saturation on the 4-bit counter instance: 20 run cycles.
    s.start = 1;
    tick();
    s.start = 0;
    tick();
    check_output("small.running", 32'(s.running), 32'd1);
    repeat (20) tick();
    check_output("small.count_sat", 32'(s.inst_count), 32'd15);
    check_output("small.pc", 32'(s.prog_counter), 32'd20);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
